// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (MAIN + SKID) between decode and execute.
// Handshake: a beat moves on a rising edge exactly when valid and ready are
// both high in that cycle. in_ready never looks at out_ready, so the upstream
// ready path is cut here. The SKID entry absorbs the one beat that can arrive
// while the downstream stalls. flush kills everything held and incoming.
// hazard only blocks capture; the head can still drain, which leaves a bubble.
module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [4:0]        in_rd,
  input  logic              hazard,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_rd,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
  logic [4:0]         main_rd_q, main_rd_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [4:0]         skid_rd_q, skid_rd_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic accept;
  logic pop;

  // Handshake decode and outputs; control and rd are masked to zero on a bubble.
  always_comb begin
    in_ready  = (state_q != ST_TWO) && !hazard && !flush;
    out_valid = (state_q != ST_EMPTY);
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = main_data_q;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    out_rd    = out_valid ? main_rd_q : 5'd0;
    bubble_cnt = bubble_cnt_q;
    flush_cnt  = flush_cnt_q;
  end

  // Next-state and entry movement; flush overrides every transition.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    main_rd_d   = main_rd_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_rd_d   = skid_rd_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            main_rd_d   = in_rd;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            main_rd_d   = in_rd;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            skid_rd_d   = in_rd;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            main_rd_d   = skid_rd_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Saturating performance counters; a flush only counts if it killed a beat.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if ((state_q == ST_EMPTY) && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    if (flush && ((state_q != ST_EMPTY) || in_valid) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State register; reset beats every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      main_rd_q    <= '0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_rd_q    <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      main_rd_q    <= main_rd_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_rd_q    <= skid_rd_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule
